// File: rtl/lsu_bank_controller.sv
// Purpose: load/store initiator for four byte-lane banks forming a 32-bit little-endian data memory.
// Latency: store/error response one cycle after handshake; load response two cycles after handshake.
// Backpressure: one transaction in flight; req_ready only in IDLE; response held stable until resp_ready.
module lsu_bank_controller #(
  parameter int DATA_DEPTH = 4096,
  parameter int ADDR_W     = $clog2(DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [31:0]       bank_wdata,
  input  logic [31:0]       bank_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        hs;
  logic        req_err;
  logic [3:0]  lane_mask;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign req_ready  = (state_q == IDLE);
  assign hs         = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Flag illegal size, misalignment and any address bit beyond the memory.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (|req_addr[31:ADDR_W+2]) begin
      req_err = 1'b1;
    end
  end

  // Drive the banks only in the handshake cycle; lane data is replicated so each lane sees its byte.
  always_comb begin
    lane_mask  = 4'b0000;
    bank_we    = 4'b0000;
    bank_addr  = '0;
    bank_wdata = 32'h0;
    case (req_size)
      2'b00:   lane_mask = 4'b0001 << req_addr[1:0];
      2'b01:   lane_mask = 4'b0011 << req_addr[1:0];
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
    if (hs) begin
      bank_addr = req_addr[ADDR_W+1:2];
      if (req_we && !req_err) begin
        bank_we = lane_mask;
        case (req_size)
          2'b00:   bank_wdata = {4{req_wdata[7:0]}};
          2'b01:   bank_wdata = {2{req_wdata[15:0]}};
          default: bank_wdata = req_wdata;
        endcase
      end
    end
  end

  // Align the returned word to the registered lane offset and extend to 32 bits.
  always_comb begin
    shifted  = bank_rdata >> {off_q, 3'b000};
    load_ext = bank_rdata;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = bank_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: loads wait one cycle for bank data, everything else goes straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = (req_we || req_err) ? RESP : LOAD;
        end
      end
      LOAD:    state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture load context at handshake and the response fields for RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q   <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (hs) begin
        off_q   <= req_addr[1:0];
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        rdata_q <= 32'h0;
        err_q   <= req_err;
      end else if (state_q == LOAD) begin
        rdata_q <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_bank_controller.sv
module tb_lsu_bank_controller;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int BYTES = 4 * DEPTH;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [3:0]    bank_we;
  logic [AW-1:0] bank_addr;
  logic [31:0]   bank_wdata;
  logic [31:0]   bank_rdata;

  int checks = 0;
  int errors = 0;

  // Reference memory, byte addressed, and the expected outcome of the current request.
  logic [7:0]  ref_mem [0:BYTES-1];
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          exp_lat;

  // Bank storage (environment, not the reference model).
  logic [7:0] bank_mem [0:3][0:DEPTH-1];

  lsu_bank_controller #(.DATA_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bank_we      (bank_we),
    .bank_addr    (bank_addr),
    .bank_wdata   (bank_wdata),
    .bank_rdata   (bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port banks with one cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      bank_rdata[8*k +: 8] <= bank_mem[k][bank_addr];
      if (bank_we[k]) bank_mem[k][bank_addr] = bank_wdata[8*k +: 8];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request, check the handshake-cycle bank controls and update the reference.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    logic       err;
    logic [3:0] we_exp;
    logic [31:0] v;
    int n;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || (addr >= 32'(BYTES));
    n = 1 << size;
    we_exp = 4'b0000;
    v = 32'h0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (we) begin
          we_exp[(addr + i) % 4] = 1'b1;
          ref_mem[addr + i] = wdata[8*i +: 8];
        end else begin
          v = v | (32'(ref_mem[addr + i]) << (8 * i));
        end
      end
      if (!we && !uns && n < 4 && v[8*n-1]) begin
        for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
      end
    end
    exp_rdata = (err || we) ? 32'h0 : v;
    exp_err   = err;
    exp_lat   = (!err && !we) ? 2 : 1;

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    #1;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    chk("bank_we_hs", {28'h0, bank_we}, {28'h0, we_exp});
    if (!err) chk("bank_addr_hs", {20'h0, bank_addr}, (addr / 4) % DEPTH);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_addr = $urandom;
  endtask

  // Wait for the response, check latency and content, optionally stall, then consume it.
  task automatic finish(input int hold);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_latency", lat, exp_lat);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, resp_valid}, 32'h1);
      chk("stall_rdata", resp_rdata, exp_rdata);
      chk("stall_err", {31'h0, resp_err}, {31'h0, exp_err});
      chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("post_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("post_req_ready", {31'h0, req_ready}, 32'h1);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata, input int hold);
    issue(we, addr, size, uns, wdata);
    finish(hold);
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    for (int a = 0; a < BYTES; a++) begin
      b = 8'($urandom);
      ref_mem[a] = b;
      bank_mem[a % 4][a / 4] = b;
    end

    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_bank_we", {28'h0, bank_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load.
    txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
    // Byte loads, signed and unsigned.
    txn(1'b0, 32'h11, 2'd0, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 0);
    // Half store into upper lanes, word readback.
    txn(1'b1, 32'h12, 2'd1, 1'b0, 32'h00001234, 0);
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
    // Misaligned and illegal-size accesses, then confirm memory untouched.
    txn(1'b0, 32'h13, 2'd1, 1'b0, 32'h0, 0);
    txn(1'b1, 32'h02, 2'd2, 1'b0, 32'hCAFEF00D, 0);
    txn(1'b1, 32'h20, 2'd3, 1'b0, 32'h55AA55AA, 0);
    txn(1'b0, 32'h00, 2'd2, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0);
    // Out of range, just past the top and a high address bit.
    txn(1'b0, 32'(BYTES), 2'd2, 1'b0, 32'h0, 0);
    txn(1'b1, 32'h8000_0010, 2'd2, 1'b0, 32'h11111111, 0);
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0);
    // Last valid word.
    txn(1'b1, 32'(BYTES - 4), 2'd2, 1'b0, 32'hA5A5_0F0F, 0);
    txn(1'b0, 32'(BYTES - 2), 2'd1, 1'b0, 32'h0, 0);
    // Load response held under backpressure.
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5);

    // Reset while the load is waiting for bank data.
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    chk("mid_load_valid", {31'h0, resp_valid}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_load_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_load_rdata", resp_rdata, 32'h0);
    chk("rst_load_err", {31'h0, resp_err}, 32'h0);
    chk("rst_load_req_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_resp_after_rst", {31'h0, resp_valid}, 32'h0);
      chk("idle_after_rst", {31'h0, req_ready}, 32'h1);
    end
    txn(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 0);

    // Randomized traffic against the byte-array reference.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] ra;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      ra = $urandom;
      else if (r == 1) ra = 32'(BYTES - 4) + $urandom_range(0, 7);
      else             ra = $urandom_range(0, 63);
      txn(1'($urandom), ra, 2'($urandom_range(0, 3)), 1'($urandom),
          $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bank_controller.md
# lsu_bank_controller

Load/store initiator that drives four byte-wide single-port memory banks (one per byte lane) as a 32-bit little-endian data memory for the RV32E core. It accepts one byte, halfword or word request at a time over a valid/ready handshake, and generates per-lane bank enables, addresses and write data. For loads it aligns and sign- or zero-extends the bank read data. It returns one response per request over a valid/ready handshake, flagging misaligned and out-of-range accesses without touching the banks.

## Interface
- DATA_DEPTH, 4096, entries per bank; total memory 4*DATA_DEPTH bytes; ADDR_W = $clog2(DATA_DEPTH)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: zero-extend (1) or sign-extend (0)
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  core consumes response
- resp_rdata  out  32  load result (0 for stores and errors)
- resp_err  out  1  misaligned, illegal size or out-of-range
- bank_we  out  4  per-lane write enable; lane k = bits [8k+7:8k]
- bank_addr  out  ADDR_W  shared word index = req_addr[ADDR_W+1:2]
- bank_wdata  out  4x8  per-lane write byte
- bank_rdata  in  4x8  per-lane read byte; valid the cycle after the address edge

## Operation
- States: IDLE, LOAD, RESP.
- IDLE: req_ready=1. Handshake = req_valid && req_ready. bank_addr, bank_we and bank_wdata are driven combinationally from the request only during a handshake cycle; otherwise bank_we=0.
- Error check at handshake: size 11; half with addr[0]=1; word with addr[1:0]!=0; or any of req_addr[31:ADDR_W+2] nonzero. On error: bank_we=0, go to RESP with err=1 and rdata=0.
- Store: lane offset o=addr[1:0]. Byte: lane o takes wdata[7:0]. Half: lanes o and o+1 take wdata[7:0] and [15:8]. Word: lanes 0..3 take wdata bytes 0..3. Only the enabled lanes are written. Then RESP with err=0 and rdata=0.
- Load: bank_we=0. Register addr[1:0], size and unsigned, then go to LOAD.
- LOAD: take bank_rdata, select lane o (byte) or lanes o+1:o (half), extend to 32 bits per the registered unsigned flag, register into resp_rdata, then go to RESP.
- RESP: resp_valid=1. Outputs are held stable until resp_ready, then return to IDLE. A new request is not accepted in the same cycle that the response is consumed.
- Only one transaction is in flight; there is no queuing.

## Timing
- Reset (async assert, sync-free release): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, bank_we=0; registered request fields are cleared.
- Reset mid-LOAD or mid-RESP abandons the transaction and no response is produced. A store whose handshake edge coincides with reset assertion is not guaranteed.
- Handshake in cycle N:
  - Store or error: resp_valid from cycle N+1.
  - Load: banks sample at edge N, data arrives in N+1, resp_valid from cycle N+2.
- With resp_ready held high, throughput is one store per 2 cycles and one load per 3 cycles.
- The bank interface has no stall; bank read latency is fixed at 1.
- req_* are don't-care outside IDLE.

## Test plan
- Reset, then word store 0xDEADBEEF at 0x10, then word load from 0x10:
  - store: bank_we=1111 at the handshake, resp err=0 at N+1
  - load: resp_rdata=0xDEADBEEF at N+2
- Byte loads from 0x11 after the word above:
  - signed: 0xFFFFFFBE
  - unsigned: 0x000000BE
- Half store 0x1234 at 0x12, then word load from 0x10:
  - store: bank_we=1100
  - load: 0x1234BEEF
- Misaligned accesses: half load at 0x13, word store at 0x02, and size 11:
  - each: resp_err=1, rdata=0, bank_we stays 0000
  - memory is unchanged (confirmed by a later load)
- Out of range: word load at 4*DATA_DEPTH gives err=1.
- Backpressure: hold resp_ready=0 for 5 cycles during a load response:
  - resp_valid, resp_rdata and resp_err stay stable, req_ready=0
  - the response completes when resp_ready=1
- Assert rst_n in the LOAD state:
  - outputs clear asynchronously, no response is issued
  - after release, req_ready=1 and the next request completes normally
